// File: rtl/control_pipeline_tracker.sv
// Carries decoded ID control bits and destination register through the EX/MEM/WB stage registers.
// Raises load-use stalls and branch flushes. Define CTRL_PIPE_STATS_EN to add stall/flush counters.
module control_pipeline_tracker #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALUOP_WIDTH    = 4,
   parameter int STATS_WIDTH    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      idValid,
   input  logic                      idRegisterDestination,
   input  logic                      idBranch,
   input  logic                      idMemoryRead,
   input  logic                      idMemoryToRegister,
   input  logic [ALUOP_WIDTH-1:0]    idALUop,
   input  logic                      idMemoryWrite,
   input  logic                      idAluSrc,
   input  logic                      idRegisterWrite,
   input  logic [REG_ADDR_WIDTH-1:0] idRs,
   input  logic [REG_ADDR_WIDTH-1:0] idRt,
   input  logic [REG_ADDR_WIDTH-1:0] idRd,
   input  logic                      branchTaken,
   output logic                      stall,
   output logic                      flush,
   output logic                      exValid,
   output logic                      exBranch,
   output logic                      exAluSrc,
   output logic                      exMemoryRead,
   output logic [ALUOP_WIDTH-1:0]    exALUop,
   output logic [REG_ADDR_WIDTH-1:0] exDest,
   output logic                      memValid,
   output logic                      memMemoryRead,
   output logic                      memMemoryWrite,
   output logic                      memMemoryToRegister,
   output logic                      memRegisterWrite,
   output logic [REG_ADDR_WIDTH-1:0] memDest,
   output logic                      wbValid,
   output logic                      wbMemoryToRegister,
   output logic                      wbRegisterWrite,
   output logic [REG_ADDR_WIDTH-1:0] wbDest
`ifdef CTRL_PIPE_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0]    stallCount,
   output logic [STATS_WIDTH-1:0]    flushCount
`endif
);

   typedef struct packed {
      logic                      valid;
      logic                      branch;
      logic                      aluSrc;
      logic                      memoryRead;
      logic                      memoryWrite;
      logic                      memoryToRegister;
      logic                      registerWrite;
      logic [ALUOP_WIDTH-1:0]    aluOp;
      logic [REG_ADDR_WIDTH-1:0] dest;
   } exStage_t;

   typedef struct packed {
      logic                      valid;
      logic                      memoryRead;
      logic                      memoryWrite;
      logic                      memoryToRegister;
      logic                      registerWrite;
      logic [REG_ADDR_WIDTH-1:0] dest;
   } memStage_t;

   typedef struct packed {
      logic                      valid;
      logic                      memoryToRegister;
      logic                      registerWrite;
      logic [REG_ADDR_WIDTH-1:0] dest;
   } wbStage_t;

   exStage_t  exStage_reg,  exStage_next;
   memStage_t memStage_reg, memStage_next;
   wbStage_t  wbStage_reg,  wbStage_next;

   logic [REG_ADDR_WIDTH-1:0] idDest;
   logic                      usesRt;
   logic                      flushRaw;
   logic                      loadUse;

   assign idDest = idRegisterDestination ? idRd : idRt;
   assign usesRt = idRegisterDestination | idMemoryWrite | idBranch;

   // The EX registerWrite is the already register-0 masked copy, so a load to r0 never stalls.
   assign flushRaw = exStage_reg.valid & exStage_reg.branch & branchTaken;
   assign loadUse  = idValid & exStage_reg.valid & exStage_reg.memoryRead
                   & exStage_reg.registerWrite & (exStage_reg.dest != '0)
                   & ((exStage_reg.dest == idRs) | (usesRt & (exStage_reg.dest == idRt)));

   assign flush = ~reset & flushRaw;
   assign stall = ~reset & loadUse & ~flushRaw;

   always_comb begin
      exStage_next = '0;
      if (idValid && !flush && !stall) begin
         exStage_next.valid            = 1'b1;
         exStage_next.branch           = idBranch;
         exStage_next.aluSrc           = idAluSrc;
         exStage_next.memoryRead       = idMemoryRead;
         exStage_next.memoryWrite      = idMemoryWrite;
         exStage_next.memoryToRegister = idMemoryToRegister;
         exStage_next.registerWrite    = idRegisterWrite & (idDest != '0);
         exStage_next.aluOp            = idALUop;
         exStage_next.dest             = idDest;
      end
   end

   always_comb begin
      memStage_next                  = '0;
      memStage_next.valid            = exStage_reg.valid;
      memStage_next.memoryRead       = exStage_reg.memoryRead;
      memStage_next.memoryWrite      = exStage_reg.memoryWrite;
      memStage_next.memoryToRegister = exStage_reg.memoryToRegister;
      memStage_next.registerWrite    = exStage_reg.registerWrite;
      memStage_next.dest             = exStage_reg.dest;
   end

   always_comb begin
      wbStage_next                  = '0;
      wbStage_next.valid            = memStage_reg.valid;
      wbStage_next.memoryToRegister = memStage_reg.memoryToRegister;
      wbStage_next.registerWrite    = memStage_reg.registerWrite;
      wbStage_next.dest             = memStage_reg.dest;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         exStage_reg  <= '0;
         memStage_reg <= '0;
         wbStage_reg  <= '0;
      end else begin
         exStage_reg  <= exStage_next;
         memStage_reg <= memStage_next;
         wbStage_reg  <= wbStage_next;
      end
   end

   assign exValid             = exStage_reg.valid;
   assign exBranch            = exStage_reg.branch;
   assign exAluSrc            = exStage_reg.aluSrc;
   assign exMemoryRead        = exStage_reg.memoryRead;
   assign exALUop             = exStage_reg.aluOp;
   assign exDest              = exStage_reg.dest;
   assign memValid            = memStage_reg.valid;
   assign memMemoryRead       = memStage_reg.memoryRead;
   assign memMemoryWrite      = memStage_reg.memoryWrite;
   assign memMemoryToRegister = memStage_reg.memoryToRegister;
   assign memRegisterWrite    = memStage_reg.registerWrite;
   assign memDest             = memStage_reg.dest;
   assign wbValid             = wbStage_reg.valid;
   assign wbMemoryToRegister  = wbStage_reg.memoryToRegister;
   assign wbRegisterWrite     = wbStage_reg.registerWrite;
   assign wbDest              = wbStage_reg.dest;

`ifdef CTRL_PIPE_STATS_EN
   // Index 0 counts stalls, index 1 counts flushes; both hold at all-ones.
   logic [1:0] statEvent;
   assign statEvent = {flush, stall};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : statGen
         logic [STATS_WIDTH-1:0] count_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               count_reg <= '0;
            end else if (statEvent[gi] && !(&count_reg)) begin
               count_reg <= count_reg + 1'b1;
            end
         end
      end
   endgenerate

   assign stallCount = statGen[0].count_reg;
   assign flushCount = statGen[1].count_reg;
`endif

endmodule

// File: doc/control_pipeline_tracker.md
Name: control_pipeline_tracker

Overview:
Downstream consumer of the decoded control bundle produced in ID (registerDestination, branch, memoryRead, memoryToRegister, ALUop, memoryWrite, AluSrc, registerWrite).
- Carries each instruction's control bits and resolved destination register through the EX, MEM and WB pipeline registers.
- Detects load-use hazards and requests an ID stall.
- Inserts bubbles on stall and on a taken-branch flush.

Parameters:
REG_ADDR_WIDTH, 5, register-number width
ALUOP_WIDTH, 4, ALUop width
STATS_WIDTH, 16, width of optional statistics counters

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
idValid  input  1  ID holds a real instruction
idRegisterDestination  input  1  1 = dest is rd, 0 = dest is rt
idBranch  input  1  beq
idMemoryRead  input  1  load
idMemoryToRegister  input  1  WB source is memory
idALUop  input  ALUOP_WIDTH  ALU operation
idMemoryWrite  input  1  store
idAluSrc  input  1  ALU B operand is immediate
idRegisterWrite  input  1  writes register file
idRs  input  REG_ADDR_WIDTH  source register rs
idRt  input  REG_ADDR_WIDTH  source/dest register rt
idRd  input  REG_ADDR_WIDTH  dest register rd
branchTaken  input  1  EX-stage beq comparison true
stall  output  1  hold PC and IF/ID this cycle (combinational)
flush  output  1  squash IF/ID this cycle (combinational)
exValid, exBranch, exAluSrc, exMemoryRead  output  1 each  EX-stage controls
exALUop  output  ALUOP_WIDTH  EX-stage ALUop
exDest  output  REG_ADDR_WIDTH  EX-stage destination register
memValid, memMemoryRead, memMemoryWrite, memMemoryToRegister, memRegisterWrite  output  1 each  MEM-stage controls
memDest  output  REG_ADDR_WIDTH  MEM-stage destination
wbValid, wbMemoryToRegister, wbRegisterWrite  output  1 each  WB-stage controls
wbDest  output  REG_ADDR_WIDTH  WB-stage destination

Behaviour:
- Three stage registers (EX, MEM, WB), each with a valid bit.
- Advance every cycle: MEM<=EX, WB<=MEM. No back-pressure downstream of ID.
- Latency: ID inputs appear on ex* 1 cycle later, mem* 2 cycles, wb* 3 cycles.
- Bubble definition: valid=0, every control bit 0, ALUop=0, dest=0.
- Reset: while reset is high at a clock edge, all three stages load bubbles.
  - All registered outputs read 0 from the first edge with reset high.
  - stall and flush are forced to 0 while reset is high.
  - Reset mid-operation discards all in-flight instructions.
- Destination resolution on ID->EX: dest = idRegisterDestination ? idRd : idRt.
- Register 0 rule: if dest==0, registerWrite is cleared as the instruction enters EX.
- flush = exValid & exBranch & branchTaken.
- usesRt = idRegisterDestination | idMemoryWrite | idBranch (R-type, sw, beq).
- Load-use stall: stall = idValid & exValid & exMemoryRead & exRegWrite(internal) & exDest!=0 & (exDest==idRs | (usesRt & exDest==idRt)), then qualified by ~flush.
- EX load, by priority:
  1. flush=1: EX loads a bubble (ID instruction squashed).
  2. stall=1: EX loads a bubble; the upstream stage re-presents the same ID instruction next cycle.
  3. otherwise: EX loads the ID bundle. EX loads a bubble if idValid=0.
- Flush and stall in the same cycle: flush wins; stall output is 0.
- Back-to-back loads: a stall lasts exactly 1 cycle, because after the bubble the load sits in MEM and no longer matches.
- An instruction with idValid=0 never raises stall.
- No hazard beyond load-use is handled here; forwarding is a separate block.

Optional Feature:
Macro: CTRL_PIPE_STATS_EN.
- Defined: adds outputs stallCount and flushCount (STATS_WIDTH each).
  - stallCount increments on every cycle with stall=1; flushCount on every cycle with flush=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with idValid=1 lw on the inputs -> all ex/mem/wb outputs 0, stall=0, flush=0; first valid instruction reaches EX on the first edge after reset deasserts.
- Pipeline latency: R-type idRd=3, ALUop=0010 at cycle 0 -> exDest=3/exALUop=0010 at cycle 1; memRegisterWrite=1 at cycle 2; wbDest=3, wbRegisterWrite=1 at cycle 3.
- Load-use:
  - lw rt=5, then R-type rs=5 -> stall=1 for exactly 1 cycle and EX bubble; R-type reaches EX the next cycle.
  - sw with rt=5 behind the lw -> same stall.
  - slti with rt=5 (usesRt=0) and rs!=5 -> no stall.
- Branch flush: beq in EX with branchTaken=1 -> flush=1, EX bubble next cycle. Same sequence with branchTaken=0 -> no bubble.
- Flush and stall together: beq in EX taken while ID holds a load-use consumer of an older lw in EX -> flush=1, stall=0.
  - Setup for this case: the lw is in EX via a directed force or an equivalent stimulus.
  - Separately: R-type with idRd=0 -> wbRegisterWrite=0, wbValid=1.
- Statistics (CTRL_PIPE_STATS_EN defined): 3 load-use stalls and 2 flushes -> stallCount=3, flushCount=2; reset -> both 0.
